multicycle_controller: RTL and testbench

Control unit for the multicycle variant of the RV32I core. The datapath shares one memory and one ALU across cycles, and this block sequences it through Fetch/Decode/Execute/Memory/Writeback steps with an 11-state Moore FSM. It also decodes immediate format and ALU operation from the instruction fields, and supports lw, sw, R-type, I-type ALU, beq and jal.

---
 rtl/multicycle_controller_pkg.sv | 62 ++++++
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 126 ++++++++++++
 tb/tb_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes
// and the datapath mux/ALU select codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } aluctl_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs between the
// multicycle datapath (master) and its controller (slave).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       Illegal;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, Illegal
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, Illegal
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation select from the main decoder's ALUOp and instruction funct fields.
module alu_decoder
    import multicycle_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output aluctl_t    alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means sub for R-type; addi reuses that bit as immediate
                    3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: 11-state Moore FSM sequencing the shared
// memory/ALU datapath, plus immediate-format and ALU-operation decode.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  ctl
);

    state_t  state;
    aluop_t  aluop;
    aluctl_t alucontrol;
    logic    pcupdate;
    logic    branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    case (ctl.op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECUTER;
                        OP_I:         state <= S_EXECUTEI;
                        OP_BEQ:       state <= S_BEQ;
                        OP_JAL:       state <= S_JAL;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= ctl.op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state <= S_MEMWB;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_JAL:      state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pcupdate      = 1'b0;
        branch        = 1'b0;
        aluop         = ALUOP_ADD;
        ctl.AdrSrc    = 1'b0;
        ctl.MemWrite  = 1'b0;
        ctl.IRWrite   = 1'b0;
        ctl.RegWrite  = 1'b0;
        ctl.Illegal   = 1'b0;
        ctl.ResultSrc = RES_ALUOUT;
        ctl.ALUSrcA   = SRCA_PC;
        ctl.ALUSrcB   = SRCB_RD2;
        case (state)
            S_FETCH: begin
                ctl.IRWrite   = 1'b1;
                ctl.ALUSrcB   = SRCB_FOUR;
                ctl.ResultSrc = RES_ALURESULT;
                pcupdate      = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BEQ can redirect straight from ALUOut
                ctl.ALUSrcA = SRCA_OLDPC;
                ctl.ALUSrcB = SRCB_IMM;
                ctl.Illegal = !op_supported(ctl.op);
            end
            S_MEMADR: begin
                ctl.ALUSrcA = SRCA_RD1;
                ctl.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: ctl.AdrSrc = 1'b1;
            S_MEMWB: begin
                ctl.ResultSrc = RES_DATA;
                ctl.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                ctl.AdrSrc   = 1'b1;
                ctl.MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ctl.ALUSrcA = SRCA_RD1;
                aluop       = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctl.ALUSrcA = SRCA_RD1;
                ctl.ALUSrcB = SRCB_IMM;
                aluop       = ALUOP_FUNCT;
            end
            S_ALUWB: ctl.RegWrite = 1'b1;
            S_BEQ: begin
                ctl.ALUSrcA = SRCA_RD1;
                aluop       = ALUOP_SUB;
                branch      = 1'b1;
            end
            S_JAL: begin
                ctl.ALUSrcA = SRCA_OLDPC;
                ctl.ALUSrcB = SRCB_FOUR;
                pcupdate    = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctl.PCWrite = pcupdate | (branch & ctl.Zero);

    always_comb begin
        case (ctl.op)
            OP_SW:   ctl.ImmSrc = IMM_S;
            OP_BEQ:  ctl.ImmSrc = IMM_B;
            OP_JAL:  ctl.ImmSrc = IMM_J;
            default: ctl.ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (ctl.funct3),
        .funct7b5   (ctl.funct7b5),
        .op5        (ctl.op[5]),
        .alucontrol (alucontrol)
    );

    assign ctl.ALUControl = alucontrol;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step sequences from an
// instruction-level reference model, with directed and random instructions.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        logic       rw, ill;
    } ctl_t;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BEQ, P_JAL} phase_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    function automatic int lat(input logic [6:0] op);
        case (op)
            LW:      return 5;
            SW:      return 4;
            RT, IT:  return 4;
            BQ:      return 3;
            JL:      return 4;
            default: return 2;
        endcase
    endfunction

    // Step list of each instruction, straight from the instruction walk-throughs
    function automatic phase_t phase_of(input logic [6:0] op, input int step);
        if (step == 0) return P_F;
        if (step == 1) return P_D;
        case (op)
            LW:      return (step == 2) ? P_MA : (step == 3) ? P_MR : P_MWB;
            SW:      return (step == 2) ? P_MA : P_MW;
            RT:      return (step == 2) ? P_ER : P_AWB;
            IT:      return (step == 2) ? P_EI : P_AWB;
            BQ:      return P_BEQ;
            default: return (step == 2) ? P_JAL : P_AWB;
        endcase
    endfunction

    function automatic ctl_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic zero, input int step);
        ctl_t e;
        int   aop;
        e = '0;
        aop = 0;
        case (phase_of(op, step))
            P_F:   begin e.pcw = 1; e.irw = 1; e.rs = 2; e.sb = 2; end
            P_D:   begin e.sa = 1; e.sb = 1; e.ill = (lat(op) == 2); end
            P_MA:  begin e.sa = 2; e.sb = 1; end
            P_MR:  e.adr = 1;
            P_MWB: begin e.rs = 1; e.rw = 1; end
            P_MW:  begin e.adr = 1; e.mw = 1; end
            P_ER:  begin e.sa = 2; aop = 2; end
            P_EI:  begin e.sa = 2; e.sb = 1; aop = 2; end
            P_AWB: e.rw = 1;
            P_BEQ: begin e.sa = 2; aop = 1; e.pcw = zero; end
            P_JAL: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            default: ;
        endcase
        e.imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
        if (aop == 1) e.alu = 3'b001;
        else if (aop == 2) begin
            case (f3)
                3'b000:  e.alu = (f7 && op[5]) ? 3'b001 : 3'b000;
                3'b010:  e.alu = 3'b101;
                3'b110:  e.alu = 3'b011;
                3'b111:  e.alu = 3'b010;
                default: e.alu = 3'b000;
            endcase
        end
        return e;
    endfunction

    function automatic ctl_t sample();
        ctl_t o;
        o.pcw = bus.PCWrite;  o.adr = bus.AdrSrc;   o.mw = bus.MemWrite;
        o.irw = bus.IRWrite;  o.rs = bus.ResultSrc; o.sa = bus.ALUSrcA;
        o.sb = bus.ALUSrcB;   o.imm = bus.ImmSrc;   o.alu = bus.ALUControl;
        o.rw = bus.RegWrite;  o.ill = bus.Illegal;
        return o;
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ctl_t e, o;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            e = model(bus.op, bus.funct3, bus.funct7b5, bus.Zero, 0);
            o = sample();
            tests++;
            if (o !== e) begin
                $display("FAIL reset_hold[%0d]: got %h want %h", i, o, e);
                fails++;
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_instr(input string name, input logic [6:0] op,
                              input logic [2:0] f3, input logic f7);
        ctl_t e, o;
        logic z;
        for (int s = 0; s < lat(op); s++) begin
            z = 1'($urandom);
            drive(op, f3, f7, z);
            e = model(op, f3, f7, z, s);
            o = sample();
            tests++;
            if (o !== e) begin
                $display("FAIL %s op=%b f3=%b f7=%b step%0d: got %h want %h",
                         name, op, f3, f7, s, o, e);
                fails++;
            end
            tick();
        end
    endtask

    task automatic test_beq_zero(input logic z);
        ctl_t e, o;
        for (int s = 0; s < 3; s++) begin
            drive(BQ, 3'($urandom), 1'($urandom), (s == 2) ? z : 1'($urandom));
            e = model(BQ, bus.funct3, bus.funct7b5, bus.Zero, s);
            o = sample();
            tests++;
            if (o !== e) begin
                $display("FAIL beq zero=%b step%0d: got %h want %h", z, s, o, e);
                fails++;
            end
            tick();
        end
        // Taken or not, the next cycle is a fresh fetch
        drive(LW, 3'd0, 1'b0, 1'b0);
        e = model(LW, 3'd0, 1'b0, 1'b0, 0);
        o = sample();
        tests++;
        if (o !== e) begin
            $display("FAIL beq_next zero=%b: got %h want %h", z, o, e);
            fails++;
        end
        test_instr("lw_after_beq", LW, 3'd2, 1'b0);
    endtask

    task automatic test_reset_mid();
        ctl_t e, o;
        for (int s = 0; s < 4; s++) begin
            drive(LW, 3'd2, 1'b0, 1'b0);
            e = model(LW, 3'd2, 1'b0, 1'b0, s);
            o = sample();
            tests++;
            if (o !== e) begin
                $display("FAIL rst_mid pre step%0d: got %h want %h", s, o, e);
                fails++;
            end
            if (s < 3) tick();
        end
        // Still in MEMREAD: reset must pull back to fetch without a clock
        reset = 1'b1;
        #1;
        e = model(LW, 3'd2, 1'b0, 1'b0, 0);
        o = sample();
        tests++;
        if (o !== e) begin
            $display("FAIL rst_mid async: got %h want %h", o, e);
            fails++;
        end
        tick();
        reset = 1'b0;
        test_instr("lw_after_reset", LW, 3'd2, 1'b0);
    endtask

    task automatic test_alu_random();
        logic [2:0] f3;
        logic       f7;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            test_instr("rtype", RT, f3, f7);
            test_instr("itype", IT, f3, f7);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [6];
        logic [6:0] op;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BQ; ops[5] = JL;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            test_instr("random", op, 3'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        #2;
        test_reset();
        test_instr("lw", LW, 3'd2, 1'b0);
        test_instr("sw", SW, 3'd2, 1'b1);
        test_instr("sub", RT, 3'b000, 1'b1);
        test_instr("addi", IT, 3'b000, 1'b1);
        test_instr("and", RT, 3'b111, 1'b0);
        test_instr("slt", RT, 3'b010, 1'b0);
        test_instr("or", IT, 3'b110, 1'b0);
        test_beq_zero(1'b1);
        test_beq_zero(1'b0);
        test_instr("jal", JL, 3'd0, 1'b0);
        test_instr("illegal", 7'b1111111, 3'd0, 1'b0);
        test_reset_mid();
        test_alu_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
